// File: rtl/serial_chan_pkg.sv
// Shared types for the serial channel bridge: receiver states and command codes.
package serial_chan_pkg;

  localparam int CMD_W = 2;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_DATA = 2'd1,
    RX_STOP = 2'd2
  } rx_state_e;

  typedef enum logic [CMD_W-1:0] {
    CMD_SEL   = 2'b00,
    CMD_DESEL = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_READ  = 2'b11
  } cmd_e;

endpackage

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W bits LSB first, STOP_BITS stop bits.
module serial_frame_rx
  import serial_chan_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en_i,
  input  logic              sel_i,
  input  logic              sdi_i,
  output logic [DATA_W-1:0] frame_byte_o,
  output logic              frame_type_o,
  output logic              frame_valid_o,
  output logic              frame_err_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  rx_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic              type_q;
  logic              valid_q;
  logic              err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      type_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (bit_en_i) begin
        case (state_q)
          RX_IDLE: if (!sdi_i) begin
            state_q <= RX_DATA;
            type_q  <= sel_i;
            cnt_q   <= '0;
          end
          RX_DATA: begin
            shift_q <= {sdi_i, shift_q[DATA_W-1:1]};
            if (cnt_q == LAST_DATA) begin
              state_q <= RX_STOP;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          RX_STOP: begin
            // A low stop bit aborts immediately; remaining stop bits are not awaited.
            if (!sdi_i) begin
              err_q   <= 1'b1;
              state_q <= RX_IDLE;
            end else if (cnt_q == LAST_STOP) begin
              valid_q <= 1'b1;
              state_q <= RX_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= RX_IDLE;
        endcase
      end
    end
  end

  assign frame_byte_o  = shift_q;
  assign frame_type_o  = type_q;
  assign frame_valid_o = valid_q;
  assign frame_err_o   = err_q;

endmodule

// File: rtl/serial_chan_bridge.sv
// Serial-addressed bank of channel registers with SEL/DESEL/WRITE/READ commands and serial readback.
module serial_chan_bridge
  import serial_chan_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int N_CH      = 4,
  parameter int STOP_BITS = 2,
  parameter int PROJ_ID   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bit_en,
  input  logic                     sel,
  input  logic                     sdi,
  output logic                     sdo,
  output logic [N_CH*DATA_W-1:0]   chan_data,
  output logic [N_CH-1:0]          chan_sel,
  output logic                     active,
  output logic                     frame_err,
  output logic                     tx_busy
);

  localparam int TX_W  = DATA_W + STOP_BITS + 1;
  localparam int TXC_W = $clog2(TX_W + 1);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int ARG_W = DATA_W - CMD_W;
  localparam logic [DATA_W-1:0] ID_L  = DATA_W'(PROJ_ID);
  localparam logic [ARG_W:0]    NCH_L = (ARG_W + 1)'(N_CH);

  logic [DATA_W-1:0] rx_byte;
  logic              rx_type, rx_valid, rx_err;

  serial_frame_rx #(.DATA_W(DATA_W), .STOP_BITS(STOP_BITS)) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .bit_en_i     (bit_en),
    .sel_i        (sel),
    .sdi_i        (sdi),
    .frame_byte_o (rx_byte),
    .frame_type_o (rx_type),
    .frame_valid_o(rx_valid),
    .frame_err_o  (rx_err)
  );

  logic                   active_q, active_d;
  logic                   sel_vld_q, sel_vld_d;
  logic [IDX_W-1:0]       sel_idx_q, sel_idx_d;
  logic                   armed_q, armed_d;
  logic [N_CH*DATA_W-1:0] chan_q, chan_d;
  logic [TX_W-1:0]        tx_sh_q, tx_sh_d;
  logic [TXC_W-1:0]       tx_cnt_q, tx_cnt_d;
  logic                   tx_busy_q, tx_busy_d;

  logic [ARG_W-1:0]  arg;
  logic [DATA_W-1:0] sel_data;

  assign arg      = rx_byte[ARG_W-1:0];
  assign sel_data = chan_q[int'(sel_idx_q)*DATA_W +: DATA_W];

  always_comb begin
    active_d  = active_q;
    sel_vld_d = sel_vld_q;
    sel_idx_d = sel_idx_q;
    armed_d   = armed_q;
    chan_d    = chan_q;
    tx_sh_d   = tx_sh_q;
    tx_cnt_d  = tx_cnt_q;
    tx_busy_d = tx_busy_q;

    // Shifter refills with ones so sdo idles high once the frame is out.
    if (tx_busy_q && bit_en) begin
      tx_sh_d  = {1'b1, tx_sh_q[TX_W-1:1]};
      tx_cnt_d = tx_cnt_q - 1'b1;
      if (tx_cnt_q == TXC_W'(1)) tx_busy_d = 1'b0;
    end

    if (rx_err) begin
      armed_d = 1'b0;
    end else if (rx_valid) begin
      if (!rx_type) begin
        active_d  = (rx_byte == ID_L);
        sel_vld_d = 1'b0;
        armed_d   = 1'b0;
      end else if (active_q) begin
        if (armed_q) begin
          if (sel_vld_q) chan_d[int'(sel_idx_q)*DATA_W +: DATA_W] = rx_byte;
          armed_d = 1'b0;
        end else begin
          case (cmd_e'(rx_byte[DATA_W-1 -: CMD_W]))
            CMD_SEL: begin
              sel_vld_d = ({1'b0, arg} < NCH_L);
              sel_idx_d = arg[IDX_W-1:0];
            end
            CMD_DESEL: sel_vld_d = 1'b0;
            CMD_WRITE: armed_d = 1'b1;
            CMD_READ: if (sel_vld_q && !tx_busy_q) begin
              tx_sh_d   = {{STOP_BITS{1'b1}}, sel_data, 1'b0};
              tx_cnt_d  = TXC_W'(TX_W);
              tx_busy_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q  <= 1'b0;
      sel_vld_q <= 1'b0;
      sel_idx_q <= '0;
      armed_q   <= 1'b0;
      chan_q    <= '0;
      tx_sh_q   <= '1;
      tx_cnt_q  <= '0;
      tx_busy_q <= 1'b0;
    end else begin
      active_q  <= active_d;
      sel_vld_q <= sel_vld_d;
      sel_idx_q <= sel_idx_d;
      armed_q   <= armed_d;
      chan_q    <= chan_d;
      tx_sh_q   <= tx_sh_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_busy_q <= tx_busy_d;
    end
  end

  always_comb begin
    chan_sel = '0;
    if (sel_vld_q) chan_sel[sel_idx_q] = 1'b1;
  end

  assign sdo       = tx_sh_q[0];
  assign chan_data = chan_q;
  assign active    = active_q;
  assign frame_err = rx_err;
  assign tx_busy   = tx_busy_q;

endmodule

// File: tb/tb_serial_chan_bridge.sv
// Bench for serial_chan_bridge: directed vector table, reset-abandon sequence, randomized frames vs. reference model.
module tb_serial_chan_bridge;

  logic        clk = 1'b0;
  logic        rst_n, bit_en, sel, sdi;
  logic        sdo, active, frame_err, tx_busy;
  logic [31:0] chan_data;
  logic [3:0]  chan_sel;

  serial_chan_bridge #(.DATA_W(8), .N_CH(4), .STOP_BITS(2), .PROJ_ID(1)) dut (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .sel(sel), .sdi(sdi),
    .sdo(sdo), .chan_data(chan_data), .chan_sel(chan_sel),
    .active(active), .frame_err(frame_err), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0, err_cnt = 0, strobe_idx = 0;
  bit got_q[$];
  bit exp_q[$];

  always @(negedge clk) if (frame_err === 1'b1) err_cnt++;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  // One bit time = 4 clocks; bit_en is high on the first. sdo is captured while busy.
  task automatic bit_time(input logic d);
    @(negedge clk);
    sdi    = d;
    bit_en = 1'b1;
    if (tx_busy === 1'b1) got_q.push_back(sdo);
    @(negedge clk);
    bit_en = 1'b0;
    repeat (2) @(negedge clk);
    strobe_idx++;
  endtask

  task automatic send_frame(input bit t, input logic [7:0] b, input int bad);
    sel = t;
    bit_time(1'b0);
    sel = 1'($urandom);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    for (int s = 0; s < 2; s++) bit_time((bad == s) ? 1'b0 : 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; bit_en = 1'b0; sdi = 1'b1; sel = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " sdo"}, 32'(sdo), 32'd1);
    chk({tag, " chan_data"}, chan_data, 32'd0);
    chk({tag, " chan_sel"}, 32'(chan_sel), 32'd0);
    chk({tag, " active"}, 32'(active), 32'd0);
    chk({tag, " frame_err"}, 32'(frame_err), 32'd0);
    chk({tag, " tx_busy"}, 32'(tx_busy), 32'd0);
  endtask

  // Reference model: register-bank view of the command protocol.
  bit         m_active, m_armed;
  int         m_sel, m_tx_free;
  logic [7:0] m_chan [4];

  function automatic void model_reset();
    m_active = 0; m_armed = 0; m_sel = -1; m_tx_free = 0;
    for (int k = 0; k < 4; k++) m_chan[k] = 8'h00;
  endfunction

  function automatic void model_frame(input bit t, input logic [7:0] b, input bit bad, input int last);
    int a;
    a = int'(b[5:0]);
    if (bad) begin
      m_armed = 0;
    end else if (!t) begin
      m_active = (b == 8'h01);
      m_sel    = -1;
      m_armed  = 0;
    end else if (m_active) begin
      if (m_armed) begin
        if (m_sel >= 0) m_chan[m_sel] = b;
        m_armed = 0;
      end else if (b[7:6] == 2'd0) begin
        m_sel = (a < 4) ? a : -1;
      end else if (b[7:6] == 2'd1) begin
        m_sel = -1;
      end else if (b[7:6] == 2'd2) begin
        m_armed = 1;
      end else if (m_sel >= 0 && last >= m_tx_free) begin
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(m_chan[m_sel][i]);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        m_tx_free = last + 11;
      end
    end
  endfunction

  function automatic logic [3:0] m_sel_vec();
    return (m_sel < 0) ? 4'b0000 : 4'(1 << m_sel);
  endfunction

  typedef struct {
    bit         t;
    logic [7:0] b;
    int         bad;
    bit         ea;
    logic [3:0] es;
    logic [31:0] ed;
    int         ee;
  } vec_t;

  vec_t tbl [19];

  initial begin
    logic [10:0] rd_frame;
    int e0;
    bit t;
    logic [7:0] b;
    int bad;

    rst_n = 1'b0; bit_en = 1'b0; sel = 1'b0; sdi = 1'b1;

    tbl[0]  = '{0, 8'h01, -1, 1, 4'b0000, 32'h00000000, 0};
    tbl[1]  = '{1, 8'h02, -1, 1, 4'b0100, 32'h00000000, 0};
    tbl[2]  = '{1, 8'h80, -1, 1, 4'b0100, 32'h00000000, 0};
    tbl[3]  = '{1, 8'hA5, -1, 1, 4'b0100, 32'h00A50000, 0};
    tbl[4]  = '{1, 8'hC0, -1, 1, 4'b0100, 32'h00A50000, 0};
    tbl[5]  = '{0, 8'h07, -1, 0, 4'b0000, 32'h00A50000, 0};
    tbl[6]  = '{1, 8'h01, -1, 0, 4'b0000, 32'h00A50000, 0};
    tbl[7]  = '{1, 8'h80, -1, 0, 4'b0000, 32'h00A50000, 0};
    tbl[8]  = '{1, 8'h3C, -1, 0, 4'b0000, 32'h00A50000, 0};
    tbl[9]  = '{0, 8'h01, -1, 1, 4'b0000, 32'h00A50000, 0};
    tbl[10] = '{1, 8'h80,  0, 1, 4'b0000, 32'h00A50000, 1};
    tbl[11] = '{1, 8'h11, -1, 1, 4'b0000, 32'h00A50000, 0};
    tbl[12] = '{1, 8'h01, -1, 1, 4'b0010, 32'h00A50000, 0};
    tbl[13] = '{1, 8'h80, -1, 1, 4'b0010, 32'h00A50000, 0};
    tbl[14] = '{1, 8'h55,  1, 1, 4'b0010, 32'h00A50000, 1};
    tbl[15] = '{1, 8'h42, -1, 1, 4'b0000, 32'h00A50000, 0};
    tbl[16] = '{1, 8'h03, -1, 1, 4'b1000, 32'h00A50000, 0};
    tbl[17] = '{1, 8'h80, -1, 1, 4'b1000, 32'h00A50000, 0};
    tbl[18] = '{1, 8'h3C, -1, 1, 4'b1000, 32'h3CA50000, 0};

    do_reset();
    chk_reset_vals("reset");

    got_q.delete();
    for (int r = 0; r < 19; r++) begin
      e0 = err_cnt;
      send_frame(tbl[r].t, tbl[r].b, tbl[r].bad);
      chk($sformatf("vec%0d active", r), 32'(active), 32'(tbl[r].ea));
      chk($sformatf("vec%0d chan_sel", r), 32'(chan_sel), 32'(tbl[r].es));
      chk($sformatf("vec%0d chan_data", r), chan_data, tbl[r].ed);
      chk($sformatf("vec%0d frame_err pulses", r), 32'(err_cnt - e0), 32'(tbl[r].ee));
    end
    repeat (12) bit_time(1'b1);

    // READ of 0xA5: start 0, data LSB first, two stop ones, busy for 11 bit times.
    rd_frame = {2'b11, 8'hA5, 1'b0};
    chk("readback length", 32'(got_q.size()), 32'd11);
    for (int i = 0; i < 11; i++)
      if (i < got_q.size()) chk($sformatf("readback bit%0d", i), 32'(got_q[i]), 32'(rd_frame[i]));
    chk("readback idle sdo", 32'(sdo), 32'd1);
    chk("readback idle tx_busy", 32'(tx_busy), 32'd0);

    // Reset in the middle of a 0xA5 write (during data bit 4), then normal decode.
    send_frame(1'b1, 8'h80, -1);
    sel = 1'b1;
    bit_time(1'b0);
    bit_time(1'b1); bit_time(1'b0); bit_time(1'b1); bit_time(1'b0);
    @(negedge clk);
    sdi = 1'b0; bit_en = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    bit_en = 1'b0; rst_n = 1'b1; sdi = 1'b1;
    @(negedge clk);
    chk_reset_vals("midframe reset");
    repeat (3) bit_time(1'b1);
    send_frame(1'b0, 8'h01, -1);
    send_frame(1'b1, 8'h01, -1);
    chk("post-reset active", 32'(active), 32'd1);
    chk("post-reset chan_sel", 32'(chan_sel), 32'b0010);
    send_frame(1'b1, 8'h80, -1);
    send_frame(1'b1, 8'h5A, -1);
    chk("post-reset write", chan_data, 32'h00005A00);

    // Randomized frames against the reference model.
    do_reset();
    model_reset();
    got_q.delete();
    exp_q.delete();
    for (int n = 0; n < 200; n++) begin
      t = ($urandom_range(0, 4) != 0);
      b = 8'($urandom);
      if (!t && $urandom_range(0, 1) == 1) b = 8'h01;
      if (t && $urandom_range(0, 1) == 1) b[5:0] = 6'($urandom_range(0, 5));
      bad = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : -1;
      e0 = err_cnt;
      send_frame(t, b, bad);
      model_frame(t, b, bad >= 0, strobe_idx);
      chk($sformatf("rand%0d active", n), 32'(active), 32'(m_active));
      chk($sformatf("rand%0d chan_sel", n), 32'(chan_sel), 32'(m_sel_vec()));
      chk($sformatf("rand%0d chan_data", n), chan_data,
          {m_chan[3], m_chan[2], m_chan[1], m_chan[0]});
      chk($sformatf("rand%0d frame_err pulses", n), 32'(err_cnt - e0), (bad >= 0) ? 32'd1 : 32'd0);
      repeat ($urandom_range(0, 2)) bit_time(1'b1);
    end
    repeat (12) bit_time(1'b1);
    chk("rand readback length", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk($sformatf("rand readback bit%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    chk("rand final tx_busy", 32'(tx_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
